pimc_sched: RTL and testbench

Interrupt delivery scheduler for the platform interrupt message controller path. It latches edges on the IRQ pins into a pending set and holds a per-line mask and target processor in MMIO-programmable config registers. A round-robin arbiter picks one eligible line at a time, and the block runs a notify/ack handshake toward the processor complex, one delivery in flight at a time, with an ack timeout.

---
 rtl/pimc_pkg.sv | 27 ++
 rtl/pimc_sched_if.sv | 31 +++
 rtl/pimc_rr_arbiter.sv | 36 +++
 rtl/pimc_sched.sv | 173 +++++++++++++++++
 tb/tb_pimc_sched.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pimc_pkg.sv
// rtl/pimc_pkg.sv - shared types and register map for the pimc interrupt scheduler
//
// Purpose: scheduler state encoding, MMIO register offsets (relative to the
// block base) and field bit positions used by the RTL and the bench.
package pimc_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } sched_state_t;

  // Register offsets relative to CFG_MMIOBASE
  localparam int          LINECFG_STRIDE = 4;
  localparam logic [47:0] PENDING_OFF    = 48'h100;
  localparam logic [47:0] PENDCLR_OFF    = 48'h104;
  localparam logic [47:0] STATUS_OFF     = 48'h108;

  // LINECFG fields
  localparam int CFG_MASK_BIT = 0;
  localparam int CFG_TGT_LSB  = 8;
  localparam int CFG_TGT_MSB  = 15;

  // STATUS fields
  localparam int STS_TIMEOUT_BIT = 0;
  localparam int STS_BUSY_BIT    = 1;

endpackage

// File: rtl/pimc_sched_if.sv
// rtl/pimc_sched_if.sv - MMIO and delivery handshake bundle for pimc_sched
//
// Signals:
//   mmio_addr/mmio_wdata/mmio_we/mmio_re  register access from the host side
//   mmio_rdata                            read data, valid the cycle after mmio_re
//   notify/lineno/processor_id            delivery request toward processors
//   irqack                                processor acknowledge
// Modports: master drives the bus (host/processor side), slave is the scheduler.
interface pimc_sched_if;

  logic [47:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_we;
  logic        mmio_re;
  logic [31:0] mmio_rdata;
  logic        notify;
  logic [7:0]  lineno;
  logic [7:0]  processor_id;
  logic        irqack;

  modport master (
    output mmio_addr, mmio_wdata, mmio_we, mmio_re, irqack,
    input  mmio_rdata, notify, lineno, processor_id
  );

  modport slave (
    input  mmio_addr, mmio_wdata, mmio_we, mmio_re, irqack,
    output mmio_rdata, notify, lineno, processor_id
  );

endinterface

// File: rtl/pimc_rr_arbiter.sv
// rtl/pimc_rr_arbiter.sv - combinational round-robin pick over an N-bit request vector
//
// Ports:
//   req_i    N-bit request vector
//   ptr_i    index where the search starts (highest priority)
//   grant_o  first requesting index at or above ptr_i, wrapping modulo N
//   valid_o  1 when any request is set
module pimc_rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          valid_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest request is the
  // last assignment and therefore the one that sticks.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        grant_o = IW'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pimc_sched.sv
// rtl/pimc_sched.sv - interrupt delivery scheduler: edge capture, mask/target config, RR notify/ack
//
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-high
//   irq_in  IRQ lines, rising-edge triggered, synchronous to clk
//   bus     pimc_sched_if.slave: MMIO register access and notify/ack handshake
module pimc_sched
  import pimc_pkg::*;
#(
  parameter int          IRQ_PIN_COUNT = 16,
  parameter int          ACK_TIMEOUT   = 1024,
  parameter logic [47:0] CFG_MMIOBASE  = 48'h2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IRQ_PIN_COUNT-1:0] irq_in,
  pimc_sched_if.slave              bus
);

  localparam int N  = IRQ_PIN_COUNT;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = (N < 32) ? N : 32;     // lines visible in PENDING/PENDCLR
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  sched_state_t  state_q, state_d;
  logic [N-1:0]  irq_q;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [7:0]    tgt_q [N];
  logic [7:0]    tgt_d [N];
  logic          sticky_q, sticky_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] line_q, line_d;
  logic [7:0]    pid_q, pid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [N-1:0]  eligible;
  logic [N-1:0]  pend_clr;
  logic [IW-1:0] grant;
  logic          grant_vld;

  // Address decode; anything below the base or off the map is unmapped.
  logic [47:0]   off;
  logic          in_blk, is_cfg, is_pend, is_pclr, is_sts;
  logic [IW-1:0] cfg_idx;

  assign off     = bus.mmio_addr - CFG_MMIOBASE;
  assign in_blk  = (bus.mmio_addr >= CFG_MMIOBASE);
  assign is_cfg  = in_blk && (off < 48'(LINECFG_STRIDE * N)) && (off[1:0] == 2'b00);
  assign is_pend = in_blk && (off == PENDING_OFF);
  assign is_pclr = in_blk && (off == PENDCLR_OFF);
  assign is_sts  = in_blk && (off == STATUS_OFF);
  assign cfg_idx = off[IW+1:2];

  assign eligible = pending_q & ~mask_q;

  pimc_rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req_i   (eligible),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (int'(v) == N - 1) return '0;
    return v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    for (int i = 0; i < N; i++) tgt_d[i] = tgt_q[i];
    sticky_d  = sticky_q;
    rr_d      = rr_q;
    line_d    = line_q;
    pid_d     = pid_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    pend_clr  = '0;
    pending_d = pending_q;

    if (bus.mmio_we) begin
      if (is_cfg) begin
        mask_d[cfg_idx] = bus.mmio_wdata[CFG_MASK_BIT];
        tgt_d[cfg_idx]  = bus.mmio_wdata[CFG_TGT_MSB:CFG_TGT_LSB];
      end
      if (is_pclr) begin
        for (int i = 0; i < PW; i++) pend_clr[i] = bus.mmio_wdata[i];
      end
      if (is_sts && bus.mmio_wdata[STS_TIMEOUT_BIT]) sticky_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = WAIT_ACK;
          line_d  = grant;
          pid_d   = tgt_q[grant];
          cnt_d   = '0;
        end
      end
      WAIT_ACK: begin
        if (bus.irqack) begin
          pend_clr[line_q] = 1'b1;
          state_d          = IDLE;
          rr_d             = wrap_inc(line_q);
        end else if (cnt_q == CNT_LAST) begin
          // Abandon: the line stays pending and is retried after the IDLE cycle.
          sticky_d = 1'b1;
          state_d  = IDLE;
          rr_d     = wrap_inc(line_q);
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // New edges win over any clear in the same cycle.
    pending_d = (pending_q & ~pend_clr) | (irq_in & ~irq_q);

    if (bus.mmio_re) begin
      rdata_d = '0;
      if (is_cfg) begin
        rdata_d[CFG_MASK_BIT]            = mask_q[cfg_idx];
        rdata_d[CFG_TGT_MSB:CFG_TGT_LSB] = tgt_q[cfg_idx];
      end else if (is_pend) begin
        for (int i = 0; i < PW; i++) rdata_d[i] = pending_q[i];
      end else if (is_sts) begin
        rdata_d[STS_TIMEOUT_BIT] = sticky_q;
        rdata_d[STS_BUSY_BIT]    = (state_q == WAIT_ACK);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      for (int i = 0; i < N; i++) tgt_q[i] <= '0;
      sticky_q  <= 1'b0;
      rr_q      <= '0;
      line_q    <= '0;
      pid_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      for (int i = 0; i < N; i++) tgt_q[i] <= tgt_d[i];
      sticky_q  <= sticky_d;
      rr_q      <= rr_d;
      line_q    <= line_d;
      pid_q     <= pid_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  // notify comes straight off the state flop so reset drops it immediately.
  assign bus.notify       = (state_q == WAIT_ACK);
  assign bus.lineno       = 8'(line_q);
  assign bus.processor_id = pid_q;
  assign bus.mmio_rdata   = rdata_q;

endmodule

// File: tb/tb_pimc_sched.sv
// tb/tb_pimc_sched.sv - directed self-checking bench for pimc_sched
module tb_pimc_sched;
  import pimc_pkg::*;

  localparam int          N    = 16;
  localparam int          TO   = 16;
  localparam logic [47:0] BASE = 48'h2000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic [31:0]  rd;
  int           hi;
  int           n_total = 0;
  int           n_pass  = 0;

  pimc_sched_if bus ();

  pimc_sched #(
    .IRQ_PIN_COUNT (N),
    .ACK_TIMEOUT   (TO),
    .CFG_MMIOBASE  (BASE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic mmio_wr(input logic [47:0] off, input logic [31:0] data);
    bus.mmio_addr  = BASE + off;
    bus.mmio_wdata = data;
    bus.mmio_we    = 1'b1;
    @(negedge clk);
    bus.mmio_we    = 1'b0;
  endtask

  task automatic mmio_rd(input logic [47:0] off, output logic [31:0] data);
    bus.mmio_addr = BASE + off;
    bus.mmio_re   = 1'b1;
    @(negedge clk);
    bus.mmio_re   = 1'b0;
    data          = bus.mmio_rdata;
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    irq_in = bits;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic ack();
    bus.irqack = 1'b1;
    @(negedge clk);
    bus.irqack = 1'b0;
  endtask

  task automatic expect_dlv(input string tag, input logic [7:0] line, input logic [7:0] pid);
    check({tag, "_notify"}, bus.notify, 1);
    check({tag, "_lineno"}, bus.lineno, line);
    check({tag, "_pid"}, bus.processor_id, pid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.mmio_addr  = '0;
    bus.mmio_wdata = '0;
    bus.mmio_we    = 1'b0;
    bus.mmio_re    = 1'b0;
    bus.irqack     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_notify", bus.notify, 0);
    check("rst_lineno", bus.lineno, 0);
    check("rst_pid", bus.processor_id, 0);
    check("rst_rdata", bus.mmio_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    mmio_rd(48'h00C, rd); check("linecfg3_rst", rd, 32'h1);
    mmio_rd(48'h03C, rd); check("linecfg15_rst", rd, 32'h1);
    mmio_rd(48'h040, rd); check("unmapped_40", rd, 32'h0);
    mmio_rd(PENDING_OFF, rd); check("pending_rst", rd, 32'h0);
    mmio_rd(STATUS_OFF, rd); check("status_rst", rd, 32'h0);

    // All masked: edges pend but never notify
    pulse('1);
    repeat (2) @(negedge clk);
    check("masked_no_notify", bus.notify, 0);
    mmio_rd(PENDING_OFF, rd); check("pending_all", rd, 32'h0000FFFF);
    mmio_wr(PENDCLR_OFF, 32'h0000FFFF);
    mmio_rd(PENDING_OFF, rd); check("pendclr_all", rd, 32'h0);
    mmio_rd(PENDCLR_OFF, rd); check("pendclr_reads0", rd, 32'h0);

    // Reserved bits ignore writes
    mmio_wr(48'h01C, 32'hFFFF00FF);
    mmio_rd(48'h01C, rd); check("linecfg7_rsvd", rd, 32'h1);

    // Single delivery on line 5
    mmio_wr(48'h014, 32'h00000700);
    mmio_rd(48'h014, rd); check("linecfg5_rb", rd, 32'h00000700);
    pulse(16'h0020);
    check("l5_one_edge", bus.notify, 0);
    @(negedge clk);
    expect_dlv("l5", 8'd5, 8'h07);
    mmio_rd(STATUS_OFF, rd); check("status_busy", rd, 32'h2);
    ack();
    check("l5_acked", bus.notify, 0);
    mmio_rd(PENDING_OFF, rd); check("l5_pending_clr", rd, 32'h0);

    // Fresh pointer for the ordering test
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    mmio_wr(48'h008, 32'h00000300);
    mmio_wr(48'h024, 32'h00000A00);
    for (int r = 0; r < 2; r++) begin
      pulse(16'h0204);
      @(negedge clk);
      expect_dlv($sformatf("rr%0d_first", r), 8'd2, 8'h03);
      ack();
      check($sformatf("rr%0d_gap", r), bus.notify, 0);
      @(negedge clk);
      expect_dlv($sformatf("rr%0d_second", r), 8'd9, 8'h0A);
      ack();
      check($sformatf("rr%0d_done", r), bus.notify, 0);
    end

    // Ack timeout on line 1
    mmio_wr(48'h004, 32'h00001100);
    pulse(16'h0002);
    @(negedge clk);
    expect_dlv("to", 8'd1, 8'h11);
    hi = 1;
    while (bus.notify && hi < 100) begin
      @(negedge clk);
      if (bus.notify) hi++;
    end
    check("to_len", hi, TO);
    mmio_rd(STATUS_OFF, rd); check("to_status", rd, 32'h1);
    expect_dlv("to_redeliver", 8'd1, 8'h11);
    mmio_rd(PENDING_OFF, rd); check("to_pending", rd, 32'h2);
    ack();
    mmio_wr(STATUS_OFF, 32'h1);
    mmio_rd(STATUS_OFF, rd); check("to_sticky_clr", rd, 32'h0);

    // Masked line 4, then unmask, mask in flight, re-edge in ack cycle
    pulse(16'h0010);
    repeat (2) @(negedge clk);
    check("l4_masked", bus.notify, 0);
    mmio_rd(PENDING_OFF, rd); check("l4_pending", rd, 32'h10);
    mmio_wr(48'h010, 32'h00000500);
    check("l4_unmask_edge", bus.notify, 0);
    @(negedge clk);
    expect_dlv("l4", 8'd4, 8'h05);
    mmio_wr(48'h010, 32'h00000501);
    check("l4_mask_hold0", bus.notify, 1);
    @(negedge clk);
    check("l4_mask_hold1", bus.notify, 1);
    irq_in     = 16'h0010;
    bus.irqack = 1'b1;
    @(negedge clk);
    irq_in     = '0;
    bus.irqack = 1'b0;
    check("l4_acked", bus.notify, 0);
    repeat (2) @(negedge clk);
    check("l4_no_redeliver", bus.notify, 0);
    mmio_rd(PENDING_OFF, rd); check("l4_repend", rd, 32'h10);
    mmio_wr(PENDCLR_OFF, 32'h10);

    // Reset during WAIT_ACK
    mmio_wr(48'h010, 32'h00000500);
    pulse(16'h0010);
    @(negedge clk);
    expect_dlv("prerst", 8'd4, 8'h05);
    #2 rst = 1'b1;
    #1;
    check("async_notify", bus.notify, 0);
    check("async_lineno", bus.lineno, 0);
    check("async_pid", bus.processor_id, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mmio_rd(48'h010, rd); check("post_rst_l4", rd, 32'h1);
    mmio_rd(48'h008, rd); check("post_rst_l2", rd, 32'h1);
    mmio_rd(PENDING_OFF, rd); check("post_rst_pending", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
